alu_ctrl_mc: RTL and testbench

Registered, parametrised ALU control decoder for the multi-cycle MIPS datapath. It extends the ALUOp space to 3 bits so immediate logic and compare ops are decoded directly. It adds shift, NOR, XOR and SLTU funct decode. It sequences iterative MULT/DIV operations through a small FSM with a start/done handshake to the mul/div unit and a HI/LO write strobe. It sits between the main control unit and the ALU / mul-div unit.

---
 rtl/alu_ctrl_mc.sv | 210 +++++++++++++++++++++
 tb/tb_alu_ctrl_mc.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_mc.sv
// Registered ALU control decoder for the multi-cycle MIPS datapath, with MULT/DIV sequencing.
// Optional mul/div watchdog enabled by defining ALU_MD_WDOG_EN.
module alu_ctrl_mc #(
    parameter int CTRL_W     = 4,
    parameter int MD_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [2:0]        ALUOp,
    input  logic [5:0]        FuncCode,
    output logic              ready,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              valid_out,
    output logic              illegal,
    output logic              md_start,
    output logic [1:0]        md_op,
    input  logic              md_done,
    output logic              hilo_we,
    output logic              md_err
);

    localparam logic [3:0] C_AND  = 4'b0000;
    localparam logic [3:0] C_OR   = 4'b0001;
    localparam logic [3:0] C_ADD  = 4'b0010;
    localparam logic [3:0] C_XOR  = 4'b0011;
    localparam logic [3:0] C_SUB  = 4'b0110;
    localparam logic [3:0] C_SLT  = 4'b0111;
    localparam logic [3:0] C_SLL  = 4'b1000;
    localparam logic [3:0] C_SRL  = 4'b1001;
    localparam logic [3:0] C_SRA  = 4'b1010;
    localparam logic [3:0] C_SLTU = 4'b1011;
    localparam logic [3:0] C_NOR  = 4'b1100;
    localparam logic [3:0] C_INV  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    // Result packing: {is_muldiv, md_op[1:0], alu code[3:0]}
    function automatic logic [6:0] decode(input logic [2:0] aluop, input logic [5:0] funct);
        logic [6:0] res;
        res = {1'b0, 2'b00, C_ADD};
        case (aluop)
            3'b000: res[3:0] = C_ADD;
            3'b001: res[3:0] = C_SUB;
            3'b010: begin
                case (funct)
                    6'b100000, 6'b100001: res[3:0] = C_ADD;
                    6'b100010, 6'b100011: res[3:0] = C_SUB;
                    6'b100100: res[3:0] = C_AND;
                    6'b100101: res[3:0] = C_OR;
                    6'b100110: res[3:0] = C_XOR;
                    6'b100111: res[3:0] = C_NOR;
                    6'b101010: res[3:0] = C_SLT;
                    6'b101011: res[3:0] = C_SLTU;
                    6'b000000: res[3:0] = C_SLL;
                    6'b000010: res[3:0] = C_SRL;
                    6'b000011: res[3:0] = C_SRA;
                    6'b011000: res = {1'b1, 2'b00, C_ADD};
                    6'b011001: res = {1'b1, 2'b01, C_ADD};
                    6'b011010: res = {1'b1, 2'b10, C_ADD};
                    6'b011011: res = {1'b1, 2'b11, C_ADD};
                    default:   res[3:0] = C_INV;
                endcase
            end
            3'b011: res[3:0] = C_AND;
            3'b100: res[3:0] = C_OR;
            3'b101: res[3:0] = C_SLT;
            3'b110: res[3:0] = C_XOR;
            3'b111: res[3:0] = C_SLTU;
            default: res[3:0] = C_INV;
        endcase
        return res;
    endfunction

    state_t            state_r;
    state_t            next_state_s;
    logic [6:0]        dec_s;
    logic              ready_s;
    logic              accept_s;
    logic              md_start_s;
    logic              hilo_we_s;
    logic [CTRL_W-1:0] alu_ctrl_r;
    logic              valid_out_r;
    logic              illegal_r;
    logic              md_start_r;
    logic [1:0]        md_op_r;
    logic              hilo_we_r;

`ifdef ALU_MD_WDOG_EN
    localparam int WD_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MD_TIMEOUT - 1);

    logic [WD_W-1:0] wd_cnt_r;
    logic            wd_expire_s;
    logic            md_err_s;
    logic            md_err_r;

    // Watchdog: held at zero outside BUSY so each op starts counting from zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt_r <= '0;
        end else if (state_r != BUSY) begin
            wd_cnt_r <= '0;
        end else begin
            wd_cnt_r <= wd_cnt_r + WD_W'(1);
        end
    end

    assign wd_expire_s = (wd_cnt_r == WD_LAST);
    assign md_err      = md_err_r;
`else
    assign md_err = 1'b0;
`endif

    assign ready_s  = (state_r == IDLE);
    assign accept_s = valid_in & ready_s;
    assign dec_s    = decode(ALUOp, FuncCode);
    assign ready    = ready_s;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state and next-cycle pulse requests
    always_comb begin
        next_state_s = state_r;
        md_start_s   = 1'b0;
        hilo_we_s    = 1'b0;
`ifdef ALU_MD_WDOG_EN
        md_err_s     = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (accept_s && dec_s[6]) begin
                    next_state_s = BUSY;
                    md_start_s   = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            BUSY: begin
                if (md_done) begin
                    next_state_s = DONE;
                    hilo_we_s    = 1'b1;
`ifdef ALU_MD_WDOG_EN
                end else if (wd_expire_s) begin
                    next_state_s = IDLE;
                    md_err_s     = 1'b1;
`endif
                end else begin
                    next_state_s = BUSY;
                end
            end
            DONE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Registered decode results and handshake pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_ctrl_r  <= '0;
            valid_out_r <= 1'b0;
            illegal_r   <= 1'b0;
            md_start_r  <= 1'b0;
            md_op_r     <= 2'b00;
            hilo_we_r   <= 1'b0;
`ifdef ALU_MD_WDOG_EN
            md_err_r    <= 1'b0;
`endif
        end else begin
            valid_out_r <= 1'b0;
            illegal_r   <= 1'b0;
            if (accept_s && !dec_s[6]) begin
                alu_ctrl_r  <= CTRL_W'(dec_s[3:0]);
                valid_out_r <= 1'b1;
                illegal_r   <= (dec_s[3:0] == C_INV);
            end
            if (accept_s && dec_s[6]) begin
                md_op_r <= dec_s[5:4];
            end
            md_start_r <= md_start_s;
            hilo_we_r  <= hilo_we_s;
`ifdef ALU_MD_WDOG_EN
            md_err_r   <= md_err_s;
`endif
        end
    end

    assign alu_ctrl  = alu_ctrl_r;
    assign valid_out = valid_out_r;
    assign illegal   = illegal_r;
    assign md_start  = md_start_r;
    assign md_op     = md_op_r;
    assign hilo_we   = hilo_we_r;

endmodule

// File: tb/tb_alu_ctrl_mc.sv
// Self-checking bench for alu_ctrl_mc: directed scenarios plus randomized traffic
// compared every cycle against a table-driven behavioural model.
module tb_alu_ctrl_mc;

    localparam int TIMEOUT = 8;
`ifdef ALU_MD_WDOG_EN
    localparam bit WDOG = 1'b1;
`else
    localparam bit WDOG = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_in;
    logic [2:0] ALUOp;
    logic [5:0] FuncCode;
    logic       md_done;
    logic       ready;
    logic [3:0] alu_ctrl;
    logic       valid_out;
    logic       illegal;
    logic       md_start;
    logic [1:0] md_op;
    logic       hilo_we;
    logic       md_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_ctrl_mc #(.CTRL_W(4), .MD_TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ALUOp(ALUOp),
        .FuncCode(FuncCode), .ready(ready), .alu_ctrl(alu_ctrl),
        .valid_out(valid_out), .illegal(illegal), .md_start(md_start),
        .md_op(md_op), .md_done(md_done), .hilo_we(hilo_we), .md_err(md_err)
    );

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference tables: expected code per funct / per ALUOp
    logic [3:0] ftab [64];
    logic [3:0] atab [8];
    logic [5:0] known [17];

    initial begin
        for (int i = 0; i < 64; i++) ftab[i] = 4'hF;
        ftab[32] = 4'h2; ftab[33] = 4'h2; ftab[34] = 4'h6; ftab[35] = 4'h6;
        ftab[36] = 4'h0; ftab[37] = 4'h1; ftab[38] = 4'h3; ftab[39] = 4'hC;
        ftab[42] = 4'h7; ftab[43] = 4'hB; ftab[0]  = 4'h8; ftab[2]  = 4'h9;
        ftab[3]  = 4'hA;
        atab = '{4'h2, 4'h6, 4'hF, 4'h0, 4'h1, 4'h7, 4'h3, 4'hB};
        known = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42,
                  6'd43, 6'd0, 6'd2, 6'd3, 6'd24, 6'd25, 6'd26, 6'd27};
    end

    // Behavioural model state
    int         m_mode = 0;   // 0 waiting for work, 1 mul/div running, 2 HI/LO writeback
    int         m_busy_n = 0;
    logic [3:0] e_alu = 4'h0;
    logic [1:0] e_mdop = 2'b00;
    logic       e_valid = 1'b0, e_ill = 1'b0, e_start = 1'b0, e_hilo = 1'b0, e_err = 1'b0;
    bit         is_md;

    // Model update on each edge, then compare all outputs shortly after
    always @(posedge clk) begin
        if (reset) begin
            m_mode = 0; e_alu = 4'h0; e_mdop = 2'b00;
            e_valid = 1'b0; e_ill = 1'b0; e_start = 1'b0; e_hilo = 1'b0; e_err = 1'b0;
        end else begin
            e_valid = 1'b0; e_ill = 1'b0; e_start = 1'b0; e_hilo = 1'b0; e_err = 1'b0;
            if (m_mode == 0) begin
                if (valid_in) begin
                    is_md = (ALUOp == 3'd2) && (FuncCode >= 6'd24) && (FuncCode <= 6'd27);
                    if (is_md) begin
                        m_mode = 1; m_busy_n = 0; e_start = 1'b1;
                        e_mdop[1] = (FuncCode == 6'd26) || (FuncCode == 6'd27);
                        e_mdop[0] = (FuncCode == 6'd25) || (FuncCode == 6'd27);
                    end else begin
                        e_alu = (ALUOp == 3'd2) ? ftab[FuncCode] : atab[ALUOp];
                        e_valid = 1'b1;
                        e_ill = (e_alu == 4'hF);
                    end
                end
            end else if (m_mode == 1) begin
                if (md_done) begin
                    m_mode = 2; e_hilo = 1'b1;
                end else if (WDOG && m_busy_n == TIMEOUT - 1) begin
                    m_mode = 0; e_err = 1'b1;
                end else begin
                    m_busy_n++;
                end
            end else begin
                m_mode = 0;
            end
        end
        #1;
        chk("m_ready",    4'(ready),     4'(m_mode == 0));
        chk("m_alu_ctrl", alu_ctrl,      e_alu);
        chk("m_valid",    4'(valid_out), 4'(e_valid));
        chk("m_illegal",  4'(illegal),   4'(e_ill));
        chk("m_md_start", 4'(md_start),  4'(e_start));
        chk("m_md_op",    4'(md_op),     4'(e_mdop));
        chk("m_hilo_we",  4'(hilo_we),   4'(e_hilo));
        chk("m_md_err",   4'(md_err),    4'(e_err));
    end

    task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] fn, input logic d);
        @(negedge clk);
        valid_in = v; ALUOp = op; FuncCode = fn; md_done = d;
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b1; valid_in = 1'b0; ALUOp = 3'd0; FuncCode = 6'd0; md_done = 1'b0;
        tick;
        chk("rst_alu", alu_ctrl, 4'h0);
        chk("rst_valid", 4'(valid_out), 4'h0);
        chk("rst_md_start", 4'(md_start), 4'h0);
        chk("rst_hilo", 4'(hilo_we), 4'h0);
        chk("rst_ready", 4'(ready), 4'h1);
        @(negedge clk); reset = 1'b0;

        drive(1'b1, 3'd0, 6'd0, 1'b0); tick;
        chk("add_alu", alu_ctrl, 4'b0010);
        chk("add_valid", 4'(valid_out), 4'h1);

        drive(1'b1, 3'd2, 6'b000011, 1'b0); tick;
        chk("sra_alu", alu_ctrl, 4'b1010);
        chk("sra_valid", 4'(valid_out), 4'h1);
        drive(1'b1, 3'd2, 6'b100111, 1'b0); tick;
        chk("nor_alu", alu_ctrl, 4'b1100);
        chk("nor_valid", 4'(valid_out), 4'h1);
        drive(1'b1, 3'd2, 6'b101011, 1'b0); tick;
        chk("sltu_alu", alu_ctrl, 4'b1011);
        chk("sltu_valid", 4'(valid_out), 4'h1);

        drive(1'b1, 3'd2, 6'b111111, 1'b0); tick;
        chk("inv_alu", alu_ctrl, 4'b1111);
        chk("inv_illegal", 4'(illegal), 4'h1);
        chk("inv_valid", 4'(valid_out), 4'h1);
        drive(1'b0, 3'd0, 6'd0, 1'b0); tick;
        chk("inv_illegal_clr", 4'(illegal), 4'h0);
        chk("idle_valid", 4'(valid_out), 4'h0);
        chk("idle_alu_hold", alu_ctrl, 4'b1111);

        // DIVU with md_done five cycles after md_start
        drive(1'b1, 3'd2, 6'b011011, 1'b0); tick;
        chk("divu_start", 4'(md_start), 4'h1);
        chk("divu_op", 4'(md_op), 4'b0011);
        chk("divu_ready", 4'(ready), 4'h0);
        chk("divu_valid", 4'(valid_out), 4'h0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'($urandom_range(0, 7)), 6'($urandom), 1'b0); tick;
            chk("busy_ready", 4'(ready), 4'h0);
            chk("busy_start", 4'(md_start), 4'h0);
            chk("busy_valid", 4'(valid_out), 4'h0);
            chk("busy_op_hold", 4'(md_op), 4'b0011);
        end
        drive(1'b0, 3'd0, 6'd0, 1'b1); tick;
        chk("divu_hilo", 4'(hilo_we), 4'h1);
        chk("done_ready", 4'(ready), 4'h0);
        drive(1'b0, 3'd0, 6'd0, 1'b0); tick;
        chk("divu_hilo_clr", 4'(hilo_we), 4'h0);
        chk("divu_ready_back", 4'(ready), 4'h1);

        // MULT aborted by asynchronous reset two cycles into BUSY
        drive(1'b1, 3'd2, 6'b011000, 1'b0); tick;
        chk("mult_start", 4'(md_start), 4'h1);
        drive(1'b0, 3'd0, 6'd0, 1'b0); tick;
        #1 reset = 1'b1;
        #1;
        chk("arst_ready", 4'(ready), 4'h1);
        chk("arst_alu", alu_ctrl, 4'h0);
        chk("arst_md_op", 4'(md_op), 4'h0);
        chk("arst_md_start", 4'(md_start), 4'h0);
        chk("arst_hilo", 4'(hilo_we), 4'h0);
        @(posedge clk);
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 3'd0, 6'd0, 1'b1); tick;
            chk("arst_no_hilo", 4'(hilo_we), 4'h0);
            chk("arst_no_start", 4'(md_start), 4'h0);
            chk("arst_ready_after", 4'(ready), 4'h1);
        end

`ifdef ALU_MD_WDOG_EN
        drive(1'b1, 3'd2, 6'b011000, 1'b0); tick;
        chk("wd_start", 4'(md_start), 4'h1);
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            drive(1'b0, 3'd0, 6'd0, 1'b0); tick;
            chk("wd_err_early", 4'(md_err), 4'h0);
            chk("wd_busy", 4'(ready), 4'h0);
        end
        drive(1'b0, 3'd0, 6'd0, 1'b0); tick;
        chk("wd_err", 4'(md_err), 4'h1);
        chk("wd_no_hilo", 4'(hilo_we), 4'h0);
        chk("wd_ready", 4'(ready), 4'h1);
        drive(1'b0, 3'd0, 6'd0, 1'b0); tick;
        chk("wd_err_clr", 4'(md_err), 4'h0);
`endif

        // Randomized traffic, checked by the model every cycle
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            valid_in = 1'($urandom_range(0, 1));
            ALUOp    = ($urandom_range(0, 2) == 0) ? 3'd2 : 3'($urandom_range(0, 7));
            FuncCode = ($urandom_range(0, 3) == 0) ? 6'($urandom) : known[$urandom_range(0, 16)];
            md_done  = ($urandom_range(0, 3) == 0);
        end
        drive(1'b0, 3'd0, 6'd0, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
